// File: rtl/mem_access_unit.sv
// ----------------------------------------------------------------------------
// mem_access_unit
//
// Purpose:
//   Sits between the multicycle CPU datapath and a slow, asynchronous-read
//   program/data memory. Each access accepted in IDLE drives the memory for
//   WAIT_CYCLES+1 chip-select cycles. It then signals completion with a
//   one-cycle mem_ready pulse. Requests are level-held by the datapath until it
//   sees mem_ready.
//
// Optional feature (compile-time macro MEM_ACCESS_WBUF_EN):
//   Adds a one-entry posted-write buffer. A write completes at T+1 and drains
//   to memory in the background (DRAIN state). A read to the buffered address
//   during the drain is forwarded from the buffer.
//
// Parameters:
//   WAIT_CYCLES  extra chip-select cycles beyond the first (0..15)
//   ADDR_W       address width
//   DATA_W       data width
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-low reset
//   address     in   access address from the datapath
//   write_data  in   store data
//   mem_read    in   read request (level)
//   mem_write   in   write request (level, wins over mem_read)
//   read_data   out  registered read result, held until the next read
//   mem_ready   out  one-cycle completion pulse
//   busy        out  FSM not IDLE or write buffer occupied
//   sram_addr   out  registered memory address
//   sram_wdata  out  registered memory write data
//   sram_cs     out  memory chip select
//   sram_we     out  memory write enable (only while sram_cs is high)
//   sram_rdata  in   asynchronous memory read data
// ----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 13,
    parameter int unsigned DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic [DATA_W-1:0] read_data,
    output logic              mem_ready,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_cs,
    output logic              sram_we,
    input  logic [DATA_W-1:0] sram_rdata
);

`ifdef MEM_ACCESS_WBUF_EN
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
`endif

    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                cs_q, cs_d;
    logic                we_q, we_d;
    logic                ready_q, ready_d;
`ifdef MEM_ACCESS_WBUF_EN
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
`endif

    // Requests are only sampled in IDLE and never while a ready pulse is out.
    // The datapath is still holding the request it just had completed during
    // that pulse, so it must not be accepted a second time.
    always_comb begin
        // NOTE: every signal gets its default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cs_d    = cs_q;
        we_d    = we_q;
        ready_d = 1'b0;
`ifdef MEM_ACCESS_WBUF_EN
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;
`endif

        case (state_q)
            IDLE: begin
                if (!ready_q) begin
                    if (mem_write) begin
                        addr_d  = address;
                        wdata_d = write_data;
                        cs_d    = 1'b1;
                        we_d    = 1'b1;
                        cnt_d   = WAIT_LD;
`ifdef MEM_ACCESS_WBUF_EN
                        // Posted: acknowledge now, write memory in DRAIN.
                        wb_valid_d = 1'b1;
                        wb_addr_d  = address;
                        wb_data_d  = write_data;
                        ready_d    = 1'b1;
                        state_d    = DRAIN;
`else
                        state_d    = ACCESS;
`endif
                    end else if (mem_read) begin
                        addr_d  = address;
                        cs_d    = 1'b1;
                        we_d    = 1'b0;
                        cnt_d   = WAIT_LD;
                        state_d = ACCESS;
                    end
                end
            end

            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q) begin
                        rdata_d = sram_rdata;
                    end
                    cs_d    = 1'b0;
                    we_d    = 1'b0;
                    ready_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

`ifdef MEM_ACCESS_WBUF_EN
            DRAIN: begin
                // Same-address read is served from the buffer. Any other
                // read stays pending and is picked up in IDLE after the drain.
                if (mem_read && !mem_write && !ready_q && wb_valid_q &&
                    (address == wb_addr_q)) begin
                    rdata_d = wb_data_q;
                    ready_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    cs_d       = 1'b0;
                    we_d       = 1'b0;
                    wb_valid_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cs_q       <= 1'b0;
            we_q       <= 1'b0;
            ready_q    <= 1'b0;
`ifdef MEM_ACCESS_WBUF_EN
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cs_q       <= cs_d;
            we_q       <= we_d;
            ready_q    <= ready_d;
`ifdef MEM_ACCESS_WBUF_EN
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
`endif
        end
    end

    assign read_data  = rdata_q;
    assign mem_ready  = ready_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign sram_cs    = cs_q;
    assign sram_we    = we_q;
`ifdef MEM_ACCESS_WBUF_EN
    assign busy = (state_q != IDLE) || wb_valid_q;
`else
    assign busy = (state_q != IDLE);
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// ----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed self-checking bench for mem_access_unit (default parameters).
// A behavioural memory answers reads asynchronously and records writes.
// Expected latencies and data are hand-computed constants. The posted-write
// scenarios are compiled in when MEM_ACCESS_WBUF_EN is defined.
// ----------------------------------------------------------------------------
module tb_mem_access_unit;

`ifdef MEM_ACCESS_WBUF_EN
    localparam int WR_RDY = 1;
`else
    localparam int WR_RDY = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] address;
    logic [7:0]  write_data;
    logic        mem_read;
    logic        mem_write;
    logic [7:0]  read_data;
    logic        mem_ready;
    logic        busy;
    logic [12:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic        sram_cs;
    logic        sram_we;
    logic [7:0]  sram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_unit dut (
        .clk        (clk),
        .rst        (rst),
        .address    (address),
        .write_data (write_data),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .read_data  (read_data),
        .mem_ready  (mem_ready),
        .busy       (busy),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_cs    (sram_cs),
        .sram_we    (sram_we),
        .sram_rdata (sram_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural memory: fixed contents until written.
    bit [7:0] mem     [8192];
    bit       mem_vld [8192];

    function automatic logic [7:0] base_val(input logic [12:0] a);
        case (a)
            13'h0123: return 8'hA5;
            13'h0041: return 8'h5A;
            default:  return a[7:0] ^ 8'h3C;
        endcase
    endfunction

    assign sram_rdata = (sram_cs && !sram_we)
                      ? (mem_vld[sram_addr] ? mem[sram_addr] : base_val(sram_addr))
                      : 8'hEE;

    always @(posedge clk) begin
        if (sram_cs && sram_we) begin
            mem[sram_addr]     <= sram_wdata;
            mem_vld[sram_addr] <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issues one request at the start of local cycle 0 (call just after a
    // rising edge) and observes it on falling edges. The request is dropped
    // after mem_ready is seen. The request fields are scrambled once the
    // memory access for it has started.
    task automatic run_req(input logic rd, input logic wr,
                           input logic [12:0] a, input logic [7:0] d,
                           output int ready_at, output int ready_n,
                           output int cs_first, output int cs_n,
                           output int we_n, output int bad);
        bit accepted = 1'b0;
        ready_at = -1; ready_n = 0; cs_first = -1; cs_n = 0; we_n = 0; bad = 0;
        mem_read = rd; mem_write = wr; address = a; write_data = d;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            if (sram_cs) begin
                cs_n++;
                if (cs_first < 0) cs_first = k;
                if (sram_we == wr) begin
                    accepted = 1'b1;
                    if (sram_addr !== a) bad++;
                    if (wr && sram_wdata !== d) bad++;
                end
            end
            if (sram_we && !sram_cs) bad++;
            if (sram_we) we_n++;
            if (mem_ready) begin
                ready_n++;
                if (ready_at < 0) ready_at = k;
            end
            @(posedge clk); #1;
            if (ready_at >= 0) begin
                mem_read = 1'b0; mem_write = 1'b0;
            end else if (accepted) begin
                address = ~a; write_data = ~d;
            end
            if (ready_at >= 0 && k >= ready_at + 3) break;
        end
        if (ready_at < 0) check("req_timeout", 32'd0, 32'd1);
    endtask

    int ra, rn, cf, cn, wn, bad, rc;

    initial begin
        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = '0; write_data = '0;
        #3;
        check("rst_dp",   {read_data, mem_ready, busy}, 32'd0);
        check("rst_sram", {sram_addr, sram_wdata, sram_cs, sram_we}, 32'd0);
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_dp",   {read_data, mem_ready, busy}, 32'd0);
        check("idle_sram", {sram_addr, sram_wdata, sram_cs, sram_we}, 32'd0);
        @(posedge clk); #1;

        // Read 0x0123: cs in cycles 1..3, ready in cycle 4.
        run_req(1'b1, 1'b0, 13'h0123, 8'h00, ra, rn, cf, cn, wn, bad);
        check("rd_rdy_at", ra, 4);
        check("rd_rdy_n",  rn, 1);
        check("rd_cs_1st", cf, 1);
        check("rd_cs_n",   cn, 3);
        check("rd_we_n",   wn, 0);
        check("rd_stable", bad, 0);
        check("rd_data",   read_data, 8'hA5);

        // Write 0x3C to 0x1FFF.
        run_req(1'b0, 1'b1, 13'h1FFF, 8'h3C, ra, rn, cf, cn, wn, bad);
        check("wr_rdy_at", ra, WR_RDY);
        check("wr_rdy_n",  rn, 1);
        check("wr_cs_1st", cf, 1);
        check("wr_cs_n",   cn, 3);
        check("wr_we_n",   wn, 3);
        check("wr_stable", bad, 0);
        check("wr_rdata",  read_data, 8'hA5);

        // Both requests: only the write is performed.
        run_req(1'b1, 1'b1, 13'h0200, 8'h99, ra, rn, cf, cn, wn, bad);
        check("both_rdy",   ra, WR_RDY);
        check("both_we_n",  wn, 3);
        check("both_cs_n",  cn, 3);
        check("both_rdata", read_data, 8'hA5);

        // Read back both writes through the unit.
        run_req(1'b1, 1'b0, 13'h1FFF, 8'h00, ra, rn, cf, cn, wn, bad);
        check("rb1_rdy",  ra, 4);
        check("rb1_data", read_data, 8'h3C);
        run_req(1'b1, 1'b0, 13'h0200, 8'h00, ra, rn, cf, cn, wn, bad);
        check("rb2_data", read_data, 8'h99);

        // Reset during the second ACCESS cycle.
        mem_read = 1'b1; address = 13'h0123;
        @(posedge clk); #1;
        check("mid_cs1",   sram_cs, 1'b1);
        check("mid_busy1", busy, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ctl",  {sram_cs, sram_we, mem_ready, busy}, 32'd0);
        check("mid_rst_data", {read_data, sram_addr}, 32'd0);
        mem_read = 1'b0;
        @(negedge clk); rst = 1'b1;
        rc = 0;
        repeat (6) begin
            @(negedge clk);
            if (mem_ready || sram_cs) rc++;
        end
        check("mid_quiet", rc, 0);
        @(posedge clk); #1;
        run_req(1'b1, 1'b0, 13'h0123, 8'h00, ra, rn, cf, cn, wn, bad);
        check("post_rst_rdy",  ra, 4);
        check("post_rst_data", read_data, 8'hA5);

`ifdef MEM_ACCESS_WBUF_EN
        // Posted write then same-address read: forwarded, no extra cs window.
        mem_write = 1'b1; address = 13'h0040; write_data = 8'h77;
        @(negedge clk);
        check("pw_rdy_t0", mem_ready, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check("pw_rdy_t1", mem_ready, 1'b1);
        check("pw_cs_t1",  {sram_cs, sram_we}, 2'b11);
        @(posedge clk); #1;
        mem_write = 1'b0;
        run_req(1'b1, 1'b0, 13'h0040, 8'h00, ra, rn, cf, cn, wn, bad);
        check("fwd_rdy_at", ra, 1);
        check("fwd_rdy_n",  rn, 1);
        check("fwd_cs_n",   cn, 2);
        check("fwd_data",   read_data, 8'h77);
        check("fwd_busy",   busy, 1'b0);

        // Posted write then different-address read: waits for the drain.
        mem_write = 1'b1; address = 13'h0040; write_data = 8'h78;
        @(posedge clk); #1;
        @(negedge clk);
        check("pw2_rdy_t1", mem_ready, 1'b1);
        @(posedge clk); #1;
        mem_write = 1'b0;
        run_req(1'b1, 1'b0, 13'h0041, 8'h00, ra, rn, cf, cn, wn, bad);
        check("miss_rdy_at", ra, 6);
        check("miss_cs_n",   cn, 5);
        check("miss_stable", bad, 0);
        check("miss_data",   read_data, 8'h5A);
        run_req(1'b1, 1'b0, 13'h0040, 8'h00, ra, rn, cf, cn, wn, bad);
        check("drain_rb_rdy",  ra, 4);
        check("drain_rb_data", read_data, 8'h78);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
